// File: rtl/hc595_chain_driver_pkg.sv
// Shared types and helpers for the 74HC595 chain driver.
// State encoding plus counter width helper.
package hc595_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DONE
  } state_t;

  // Width for a counter running 0..n-1, never below 1.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hc595_chain_driver_if.sv
// Request/serial bundle between control logic and the chain driver.
// master drives requests, slave is the driver itself.
interface hc595_chain_driver_if #(
  parameter int W = 16
);
  logic         en;
  logic         shift;
  logic [W-1:0] data;
  logic         sda;
  logic         sck;
  logic         rck;
  logic         busy;
  logic         done;

  modport master (
    output en, shift, data,
    input  sda, sck, rck, busy, done
  );

  modport slave (
    input  en, shift, data,
    output sda, sck, rck, busy, done
  );
endinterface

// File: rtl/hc595_chain_driver_sck_tick_gen.sv
// Half-period timer for sck: pulses tick on the last of DIV cycles.
// Frozen by en, restarted by clear.
module sck_tick_gen
  import hc595_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);
  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clear && (cnt == LAST);

  // Count cycles within the half-period, wrap on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clear || tick) cnt <= '0;
      else               cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/hc595_chain_driver.sv
// Serial driver for a cascade of NUM_CHIPS 74HC595 registers.
// Shifts a captured word out on sda/sck, then strobes rck.
module hc595_chain_driver
  import hc595_pkg::*;
#(
  parameter int NUM_CHIPS = 2,
  parameter int DIV       = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic clk,
  input  logic rst,
  hc595_chain_driver_if.slave bus
);
  localparam int W  = 8 * NUM_CHIPS;
  localparam int BW = cnt_w(W);
  localparam logic [BW-1:0] LASTBIT = BW'(W - 1);

  state_t        state;
  logic [W-1:0]  sreg;
  logic [W-1:0]  sreg_nx;
  logic [BW-1:0] bit_cnt;
  logic          tick;
  logic          clear;

  // Timer idles in IDLE/DONE so every transfer starts on a fresh count.
  assign clear = (state == IDLE) || (state == DONE);

  sck_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clear(clear),
    .tick (tick)
  );

  // sda is the head flop of the shift register, so it is registered.
  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign bus.sda = sreg[0];
      assign sreg_nx = {1'b0, sreg[W-1:1]};
    end else begin : g_msb
      assign bus.sda = sreg[W-1];
      assign sreg_nx = {sreg[W-2:0], 1'b0};
    end
  endgenerate

  // Transfer sequencer: capture, shift W bits, latch, report done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      bus.sck  <= 1'b0;
      bus.rck  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else if (bus.en) begin
      unique case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          bus.sck  <= 1'b0;
          bus.rck  <= 1'b0;
          // A request seen as DONE retires starts the next transfer.
          if (bus.shift) begin
            state    <= SHIFT;
            sreg     <= bus.data;
            bit_cnt  <= '0;
            bus.busy <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!bus.sck) begin
              bus.sck <= 1'b1;
            end else begin
              bus.sck <= 1'b0;
              if (bit_cnt == LASTBIT) begin
                state   <= LATCH;
                bus.rck <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sreg    <= sreg_nx;
              end
            end
          end
        end
        LATCH: begin
          if (tick) begin
            state    <= DONE;
            bus.rck  <= 1'b0;
            bus.done <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hc595_chain_driver.sv
// Directed bench for hc595_chain_driver.
// Three instances: MSB-first, LSB-first, DIV=1 single chip.
module tb_hc595_chain_driver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hc595_chain_driver_if #(.W(16)) ia ();
  hc595_chain_driver_if #(.W(16)) ib ();
  hc595_chain_driver_if #(.W(8))  ic ();

  logic        en;
  logic        shift;
  logic [15:0] din;
  logic        shift_c;
  logic [7:0]  din_c;

  assign ia.en    = en;
  assign ia.shift = shift;
  assign ia.data  = din;
  assign ib.en    = en;
  assign ib.shift = shift;
  assign ib.data  = din;
  assign ic.en    = 1'b1;
  assign ic.shift = shift_c;
  assign ic.data  = din_c;

  hc595_chain_driver #(
    .NUM_CHIPS(2), .DIV(2), .LSB_FIRST(0)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia));

  hc595_chain_driver #(
    .NUM_CHIPS(2), .DIV(2), .LSB_FIRST(1)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib));

  hc595_chain_driver #(
    .NUM_CHIPS(1), .DIV(1), .LSB_FIRST(0)
  ) dut_c (.clk(clk), .rst(rst), .bus(ic));

  int tests = 0;
  int fails = 0;

  logic [15:0] bits_a, bits_b;
  int nra, nrb;
  int rck_j, rck_n, done_j, done_n;
  int rck_jb, done_jb;
  logic busy_end;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0 plain, 1 re-request while busy, 2 en pause, 3 reset
  task automatic run(input logic [15:0] d,
                     input int mode,
                     input int len);
    logic pa, pb, sda22;
    bits_a = '0; bits_b = '0;
    nra = 0; nrb = 0;
    rck_j = -1; rck_n = 0;
    done_j = -1; done_n = 0;
    rck_jb = -1; done_jb = -1;
    pa = 1'b0; pb = 1'b0; sda22 = 1'b0;
    @(negedge clk);
    din = d;
    shift = 1'b1;
    @(posedge clk);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      if (ia.sck && !pa) begin
        bits_a = {bits_a[14:0], ia.sda};
        nra++;
      end
      if (ib.sck && !pb) begin
        bits_b = {bits_b[14:0], ib.sda};
        nrb++;
      end
      pa = ia.sck;
      pb = ib.sck;
      if (ia.rck) begin
        if (rck_j < 0) rck_j = j;
        rck_n++;
      end
      if (ia.done) begin
        if (done_j < 0) done_j = j;
        done_n++;
      end
      if (ib.rck && rck_jb < 0) rck_jb = j;
      if (ib.done && done_jb < 0) done_jb = j;
      if (j == 0) begin
        shift = 1'b0;
        din = 16'h0000;
      end
      if (mode == 1 && j == 10) begin
        shift = 1'b1;
        din = 16'hFFFF;
      end
      if (mode == 1 && j == 30) shift = 1'b0;
      if (mode == 2 && j == 22) begin
        sda22 = ia.sda;
        en = 1'b0;
      end
      if (mode == 2 && j == 28) begin
        check("pause_sck", ia.sck, 1);
        check("pause_sda", ia.sda, sda22);
      end
      if (mode == 2 && j == 29) en = 1'b1;
      if (mode == 3 && j == 37) begin
        rst = 1'b1;
        #1;
        check("rst_sda", ia.sda, 0);
        check("rst_sck", ia.sck, 0);
        check("rst_rck", ia.rck, 0);
        check("rst_busy", ia.busy, 0);
        check("rst_done", ia.done, 0);
      end
      if (mode == 3 && j == 40) rst = 1'b0;
    end
    busy_end = ia.busy;
  endtask

  initial begin
    int d1, d2, d3;
    logic [7:0] bits_c;
    logic pc, busy18;
    int nrc;
    rst = 1'b1;
    en = 1'b1;
    shift = 1'b0;
    din = '0;
    shift_c = 1'b0;
    din_c = '0;
    repeat (3) @(negedge clk);
    check("reset_sda", ia.sda, 0);
    check("reset_sck", ia.sck, 0);
    check("reset_rck", ia.rck, 0);
    check("reset_busy", ia.busy, 0);
    check("reset_done", ia.done, 0);
    rst = 1'b0;
    @(negedge clk);

    run(16'h4ADE, 0, 70);
    check("basic_bits", bits_a, 16'h4ADE);
    check("basic_nrise", nra, 16);
    check("basic_rck_j", rck_j, 64);
    check("basic_rck_n", rck_n, 2);
    check("basic_done_j", done_j, 66);
    check("basic_done_n", done_n, 1);
    check("basic_busy_end", busy_end, 0);
    check("lsb_bits", bits_b, 16'h7B52);
    check("lsb_nrise", nrb, 16);
    check("lsb_rck_j", rck_jb, 64);
    check("lsb_done_j", done_jb, 66);

    run(16'h4ADE, 1, 70);
    check("busy_bits", bits_a, 16'h4ADE);
    check("busy_rck_j", rck_j, 64);
    check("busy_done_j", done_j, 66);
    check("busy_done_n", done_n, 1);
    check("busy_busy_end", busy_end, 0);

    run(16'h4ADE, 2, 80);
    check("pause_bits", bits_a, 16'h4ADE);
    check("pause_nrise", nra, 16);
    check("pause_rck_j", rck_j, 71);
    check("pause_done_j", done_j, 73);
    check("pause_lsb", bits_b, 16'h7B52);

    run(16'h4ADE, 3, 70);
    check("rst_no_rck", rck_n, 0);
    check("rst_no_done", done_n, 0);

    run(16'h00FF, 0, 70);
    check("post_bits", bits_a, 16'h00FF);
    check("post_lsb", bits_b, 16'hFF00);
    check("post_rck_j", rck_j, 64);
    check("post_done_j", done_j, 66);

    d1 = -1; d2 = -1; d3 = -1;
    bits_c = '0;
    nrc = 0;
    pc = 1'b0;
    busy18 = 1'b0;
    @(negedge clk);
    din_c = 8'hA5;
    shift_c = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (ic.sck && !pc && nrc < 8) begin
        bits_c = {bits_c[6:0], ic.sda};
        nrc++;
      end
      pc = ic.sck;
      if (ic.done) begin
        if (d1 < 0) d1 = j;
        else if (d2 < 0) d2 = j;
        else if (d3 < 0) d3 = j;
      end
      if (j == 18) busy18 = ic.busy;
    end
    shift_c = 1'b0;
    check("b2b_bits", bits_c, 8'hA5);
    check("b2b_done1", d1, 17);
    check("b2b_period1", d2 - d1, 18);
    check("b2b_period2", d3 - d2, 18);
    check("b2b_busy_hold", busy18, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
